// File: rtl/hssl_rx_link_monitor.sv
// RX link-state monitor for a 4-byte 8b/10b transceiver lane: hunts for commas, verifies
// alignment, forwards data while in sync and requests a datapath reset when acquisition stalls.
module hssl_rx_link_monitor #(
   parameter int SYNC_CNT  = 16,
   parameter int ERR_LIMIT = 4,
   parameter int ERR_WIN   = 256,
   parameter int TIMEOUT   = 65535,
   parameter int RST_LEN   = 16
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [31:0] rx_data_in,
   input  logic [3:0]  rx_charisk_in,
   input  logic [3:0]  rx_disperr_in,
   input  logic [3:0]  rx_encerr_in,
   input  logic        rx_reset_done_in,
   output logic [31:0] data_out,
   output logic        data_vld_out,
   output logic        link_up_out,
   output logic        rx_reset_datapath_out,
   output logic [15:0] err_cnt_out,
   output logic [7:0]  resync_cnt_out
);
   localparam int GW = $clog2(SYNC_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int WW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

   localparam logic [GW-1:0] GOOD_MAX = GW'(SYNC_CNT);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
   localparam logic [WW-1:0] WIN_MAX  = WW'(ERR_WIN - 1);
   localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);
   localparam logic [RW-1:0] RST_MAX  = RW'(RST_LEN - 1);

   typedef enum logic [2:0] {WAIT_RST, HUNT, VERIFY, SYNC, RESYNC_REQ} state_t;
   typedef enum logic [1:0] {CL_ERR, CL_COMMA, CL_DATA, CL_CTRL} cls_t;

   state_t        st;
   cls_t          cls;
   logic [GW-1:0] good, good_inc;
   logic [TW-1:0] tmo, tmo_inc;
   logic [WW-1:0] win;
   logic [EW-1:0] werr, werr_inc;
   logic [RW-1:0] rcnt;
   logic [31:0]   data;
   logic          vld, link, rreq;
   logic [15:0]   err_cnt;
   logic [7:0]    rsc;

   // Errors dominate: a comma with a code violation must not count toward alignment.
   always_comb begin
      if (|(rx_disperr_in | rx_encerr_in))                        cls = CL_ERR;
      else if (rx_charisk_in == 4'b0001 && rx_data_in[7:0] == 8'hBC) cls = CL_COMMA;
      else if (rx_charisk_in == 4'b0000)                          cls = CL_DATA;
      else                                                         cls = CL_CTRL;
   end

   assign good_inc = good + 1'b1;
   assign tmo_inc  = tmo + 1'b1;
   assign werr_inc = werr + EW'(cls == CL_ERR);

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         st      <= WAIT_RST;
         good    <= '0;
         tmo     <= '0;
         win     <= '0;
         werr    <= '0;
         rcnt    <= '0;
         data    <= '0;
         vld     <= 1'b0;
         link    <= 1'b0;
         rreq    <= 1'b0;
         err_cnt <= '0;
         rsc     <= '0;
      end else begin
         vld <= 1'b0;
         if (st == SYNC && cls == CL_DATA) begin
            data <= rx_data_in;
            vld  <= 1'b1;
         end
         if (st != WAIT_RST && cls == CL_ERR && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 1'b1;
         // Acquisition timer spans HUNT and VERIFY together; any other state clears it.
         tmo <= (st == HUNT || st == VERIFY) ? tmo_inc : '0;

         case (st)
            WAIT_RST:
               if (rx_reset_done_in) st <= HUNT;
            HUNT, VERIFY:
               if (!rx_reset_done_in) begin
                  st <= WAIT_RST;
               end else if (tmo_inc == TMO_MAX) begin
                  st   <= RESYNC_REQ;
                  rreq <= 1'b1;
                  rcnt <= '0;
                  if (rsc != 8'hFF) rsc <= rsc + 1'b1;
               end else if (st == HUNT) begin
                  if (cls == CL_COMMA) begin
                     st   <= VERIFY;
                     good <= GW'(1);
                  end
               end else if (cls == CL_ERR) begin
                  st   <= HUNT;
                  good <= '0;
               end else if (cls != CL_CTRL) begin
                  good <= good_inc;
                  if (good_inc == GOOD_MAX) begin
                     st   <= SYNC;
                     link <= 1'b1;
                     win  <= '0;
                     werr <= '0;
                  end
               end
            SYNC: begin
               win <= (win == WIN_MAX) ? '0 : win + 1'b1;
               if (!rx_reset_done_in) begin
                  st   <= WAIT_RST;
                  link <= 1'b0;
               end else if (werr_inc == ERR_MAX) begin
                  // Limit hit on the wrap cycle still drops the link before the count clears.
                  st   <= HUNT;
                  link <= 1'b0;
                  good <= '0;
               end else begin
                  werr <= (win == WIN_MAX) ? '0 : werr_inc;
               end
            end
            RESYNC_REQ: begin
               rcnt <= rcnt + 1'b1;
               if (rcnt == RST_MAX) begin
                  st   <= WAIT_RST;
                  rreq <= 1'b0;
               end
            end
            default: st <= WAIT_RST;
         endcase
      end
   end

   assign data_out              = data;
   assign data_vld_out          = vld;
   assign link_up_out           = link;
   assign rx_reset_datapath_out = rreq;
   assign err_cnt_out           = err_cnt;
   assign resync_cnt_out        = rsc;
endmodule
